// File: rtl/bufid_alloc_if.sv
// Handshake bundle between the bufid allocator and its two injection paths
// plus the release/free-count side.
interface bufid_alloc_if #(
  parameter int BUFID_WIDTH = 9
);
  logic                   i_host_bufid_req;
  logic                   o_host_bufid_ack;
  logic [BUFID_WIDTH-1:0] ov_host_bufid;
  logic                   i_net_bufid_req;
  logic                   o_net_bufid_ack;
  logic [BUFID_WIDTH-1:0] ov_net_bufid;
  logic                   i_release_wr;
  logic [BUFID_WIDTH-1:0] iv_release_bufid;
  logic [BUFID_WIDTH-1:0] ov_free_bufid_num;
  logic                   o_init_done;
  logic [15:0]            ov_release_err_cnt;

  modport master (
    output i_host_bufid_req, i_net_bufid_req, i_release_wr, iv_release_bufid,
    input  o_host_bufid_ack, ov_host_bufid, o_net_bufid_ack, ov_net_bufid,
           ov_free_bufid_num, o_init_done, ov_release_err_cnt
  );

  modport slave (
    input  i_host_bufid_req, i_net_bufid_req, i_release_wr, iv_release_bufid,
    output o_host_bufid_ack, ov_host_bufid, o_net_bufid_ack, ov_net_bufid,
           ov_free_bufid_num, o_init_done, ov_release_err_cnt
  );
endinterface

// File: rtl/bufid_alloc_arbiter.sv
// Packet-buffer ID free pool with round-robin host/network allocation and release path.
// Optional macro BUFID_DOUBLE_RELEASE_CHECK_EN adds an in-use bitmap that rejects double releases.
module bufid_alloc_arbiter #(
  parameter int BUFID_WIDTH = 9,
  parameter int BUFID_NUM   = 256
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  bufid_alloc_if.slave   bus
);

  localparam int IDX_W = (BUFID_NUM > 1) ? $clog2(BUFID_NUM) : 1;
  localparam int CNT_W = $clog2(BUFID_NUM + 1);
  localparam logic [CNT_W-1:0]     NUM_C    = CNT_W'(BUFID_NUM);
  localparam logic [BUFID_WIDTH:0] NUM_ID   = (BUFID_WIDTH + 1)'(BUFID_NUM);
  localparam logic [IDX_W-1:0]     LAST_PTR = IDX_W'(BUFID_NUM - 1);

  typedef enum logic [0:0] {INIT_S, WORK_S} state_t;

  state_t                 state_q, state_d;
  logic [BUFID_WIDTH-1:0] mem [0:BUFID_NUM-1];
  logic [IDX_W-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]       count_q, free_num_q;
  logic                   last_host_q;
  logic                   host_ack_q, net_ack_q, init_done_q;
  logic [BUFID_WIDTH-1:0] host_bufid_q, net_bufid_q;
  logic [15:0]            err_cnt_q;

  logic                   fill_last, grant_host, grant_net, grant_any;
  logic                   rel_ok, rel_bad, rel_oor, rel_dbl;
  logic [BUFID_WIDTH-1:0] head;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign head      = mem[rd_ptr_q];
  assign rel_oor   = {1'b0, bus.iv_release_bufid} >= NUM_ID;
  assign grant_any = grant_host | grant_net;

`ifdef BUFID_DOUBLE_RELEASE_CHECK_EN
  logic [BUFID_NUM-1:0] in_use_q;
  assign rel_dbl = !rel_oor && !in_use_q[IDX_W'(bus.iv_release_bufid)];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_use_q <= '0;
    end else begin
      if (grant_any) in_use_q[IDX_W'(head)] <= 1'b1;
      if (rel_ok)    in_use_q[IDX_W'(bus.iv_release_bufid)] <= 1'b0;
    end
  end
`else
  assign rel_dbl = 1'b0;
`endif

  // Arbitration and release qualification; both use the pre-update count, so
  // a release into an empty pool cannot be granted in the same cycle.
  always_comb begin
    state_d    = state_q;
    fill_last  = 1'b0;
    grant_host = 1'b0;
    grant_net  = 1'b0;
    rel_ok     = 1'b0;
    rel_bad    = 1'b0;
    case (state_q)
      INIT_S: begin
        fill_last = (wr_ptr_q == LAST_PTR);
        if (fill_last) state_d = WORK_S;
        rel_bad = bus.i_release_wr;
      end
      WORK_S: begin
        if (count_q != '0) begin
          if (bus.i_host_bufid_req && bus.i_net_bufid_req) begin
            grant_host = !last_host_q;
            grant_net  = last_host_q;
          end else begin
            grant_host = bus.i_host_bufid_req;
            grant_net  = bus.i_net_bufid_req;
          end
        end
        if (bus.i_release_wr) begin
          if (rel_oor || (count_q == NUM_C) || rel_dbl) rel_bad = 1'b1;
          else                                          rel_ok  = 1'b1;
        end
      end
      default: state_d = INIT_S;
    endcase
  end

  // Registered control and grant outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= INIT_S;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      free_num_q   <= '0;
      last_host_q  <= 1'b1;
      host_ack_q   <= 1'b0;
      net_ack_q    <= 1'b0;
      host_bufid_q <= '0;
      net_bufid_q  <= '0;
      init_done_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      host_ack_q <= grant_host;
      net_ack_q  <= grant_net;
      if (grant_host) host_bufid_q <= head;
      if (grant_net)  net_bufid_q  <= head;
      if (grant_any) begin
        rd_ptr_q    <= ptr_inc(rd_ptr_q);
        last_host_q <= grant_host;
      end
      if ((state_q == INIT_S) || rel_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fill_last) begin
        count_q     <= NUM_C;
        init_done_q <= 1'b1;
      end else if (rel_ok && !grant_any) begin
        count_q <= count_q + 1'b1;
      end else if (!rel_ok && grant_any) begin
        count_q <= count_q - 1'b1;
      end
      free_num_q <= (state_q == WORK_S) ? count_q : '0;
      if (rel_bad) err_cnt_q <= sat_inc16(err_cnt_q);
    end
  end

  // Free-list storage holds data only, so it carries no reset
  always_ff @(posedge i_clk) begin
    if (state_q == INIT_S) mem[wr_ptr_q] <= BUFID_WIDTH'(wr_ptr_q);
    else if (rel_ok)       mem[wr_ptr_q] <= bus.iv_release_bufid;
  end

  assign bus.o_host_bufid_ack   = host_ack_q;
  assign bus.ov_host_bufid      = host_bufid_q;
  assign bus.o_net_bufid_ack    = net_ack_q;
  assign bus.ov_net_bufid       = net_bufid_q;
  assign bus.ov_free_bufid_num  = BUFID_WIDTH'(free_num_q);
  assign bus.o_init_done        = init_done_q;
  assign bus.ov_release_err_cnt = err_cnt_q;

endmodule
